// File: rtl/sdec_step_counter.sv
// sdec_step_counter
//   Registered signed up/down counter with a programmable step, parallel load
//   and selectable saturating or wrapping arithmetic. It flags any step that
//   leaves the signed range with a one-cycle pulse and with a sticky flag.
//
// Ports
//   Clk         rising-edge clock
//   Rst_n       synchronous reset, active low
//   load        load load_val into the count (takes priority over en)
//   load_val    signed value to load
//   en          apply one step this cycle
//   dir         0 = decrement by step, 1 = increment by step
//   step        unsigned step magnitude
//   clr_ovf     clear the sticky overflow flag
//   d           signed count value (registered)
//   at_min      d equals the signed minimum
//   at_max      d equals the signed maximum
//   ovf         one-cycle pulse: the last step left the signed range
//   ovf_sticky  set by ovf, held until clr_ovf
module sdec_step_counter #(
    parameter int DATAWIDTH = 8,
    parameter int STEPWIDTH = 4,
    parameter bit SATURATE  = 1'b1,
    parameter int RESET_VAL = 0
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 load,
    input  logic [DATAWIDTH-1:0] load_val,
    input  logic                 en,
    input  logic                 dir,
    input  logic [STEPWIDTH-1:0] step,
    input  logic                 clr_ovf,
    output logic [DATAWIDTH-1:0] d,
    output logic                 at_min,
    output logic                 at_max,
    output logic                 ovf,
    output logic                 ovf_sticky
);

    localparam logic [DATAWIDTH-1:0] MIN_V = {1'b1, {(DATAWIDTH-1){1'b0}}};
    localparam logic [DATAWIDTH-1:0] MAX_V = ~MIN_V;
    localparam logic [DATAWIDTH-1:0] RST_V = DATAWIDTH'(RESET_VAL);

    logic [DATAWIDTH-1:0] d_q, d_d;
    logic                 ovf_q, ovf_d;
    logic                 sticky_q, sticky_d;
    logic                 at_min_q, at_min_d;
    logic                 at_max_q, at_max_d;

    logic [DATAWIDTH:0]   d_x, step_x, nxt;
    logic                 out_of_range;

    always_comb begin
        // One guard bit is enough: any overflow of the true sum lands the
        // (DATAWIDTH+1)-bit result outside [MIN, MAX], so the top two bits
        // disagree exactly when the step left the signed range.
        d_x          = {d_q[DATAWIDTH-1], d_q};
        step_x       = {{(DATAWIDTH+1-STEPWIDTH){1'b0}}, step};
        nxt          = dir ? (d_x + step_x) : (d_x - step_x);
        out_of_range = nxt[DATAWIDTH] ^ nxt[DATAWIDTH-1];

        d_d   = d_q;
        ovf_d = 1'b0;
        if (load) begin
            d_d = load_val;
        end else if (en) begin
            if (out_of_range) begin
                ovf_d = 1'b1;
                if (SATURATE) d_d = dir ? MAX_V : MIN_V;
                else          d_d = nxt[DATAWIDTH-1:0];
            end else begin
                d_d = nxt[DATAWIDTH-1:0];
            end
        end

        // A new overflow wins over a simultaneous clear.
        sticky_d = (sticky_q & ~clr_ovf) | ovf_d;
        at_min_d = (d_d == MIN_V);
        at_max_d = (d_d == MAX_V);
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            d_q      <= RST_V;
            ovf_q    <= 1'b0;
            sticky_q <= 1'b0;
            at_min_q <= (RST_V == MIN_V);
            at_max_q <= (RST_V == MAX_V);
        end else begin
            d_q      <= d_d;
            ovf_q    <= ovf_d;
            sticky_q <= sticky_d;
            at_min_q <= at_min_d;
            at_max_q <= at_max_d;
        end
    end

    assign d          = d_q;
    assign ovf        = ovf_q;
    assign ovf_sticky = sticky_q;
    assign at_min     = at_min_q;
    assign at_max     = at_max_q;

endmodule

// File: tb/tb_sdec_step_counter.sv
// Bench for sdec_step_counter: a saturating and a wrapping instance
// (DATAWIDTH=4, STEPWIDTH=2, RESET_VAL=3) share one stimulus stream. Each
// driven cycle pushes the expected state of both into a queue; a monitor
// pops one entry after every rising edge and compares.
module tb_sdec_step_counter;

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = '0;
    logic       en = 1'b0;
    logic       dir = 1'b0;
    logic [1:0] step = '0;
    logic       clr_ovf = 1'b0;

    logic [3:0] d_s, d_w;
    logic       amin_s, amax_s, ovf_s, stk_s;
    logic       amin_w, amax_w, ovf_w, stk_w;

    always #5 Clk = ~Clk;

    sdec_step_counter #(.DATAWIDTH(4), .STEPWIDTH(2), .SATURATE(1'b1), .RESET_VAL(3)) u_sat (
        .Clk(Clk), .Rst_n(Rst_n), .load(load), .load_val(load_val), .en(en), .dir(dir),
        .step(step), .clr_ovf(clr_ovf), .d(d_s), .at_min(amin_s), .at_max(amax_s),
        .ovf(ovf_s), .ovf_sticky(stk_s));

    sdec_step_counter #(.DATAWIDTH(4), .STEPWIDTH(2), .SATURATE(1'b0), .RESET_VAL(3)) u_wrap (
        .Clk(Clk), .Rst_n(Rst_n), .load(load), .load_val(load_val), .en(en), .dir(dir),
        .step(step), .clr_ovf(clr_ovf), .d(d_w), .at_min(amin_w), .at_max(amax_w),
        .ovf(ovf_w), .ovf_sticky(stk_w));

    typedef struct {
        int d   [2];
        int ovf [2];
        int stk [2];
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    // Reference state: index 0 = saturating, 1 = wrapping.
    int md[2];
    int ms[2];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int wrap4(input int v);
        int m;
        m = (v + 8) % 16;
        if (m < 0) m += 16;
        return m - 8;
    endfunction

    task automatic cyc(input logic rst_i, input logic ld_i, input int lv, input logic en_i,
                       input logic dir_i, input int st, input logic clr_i);
        exp_t e;
        int   n;
        int   o;
        @(negedge Clk);
        Rst_n = rst_i; load = ld_i; load_val = 4'(lv); en = en_i; dir = dir_i;
        step = 2'(st); clr_ovf = clr_i;
        for (int s = 0; s < 2; s++) begin
            o = 0;
            if (!rst_i) begin
                md[s] = 3;
                ms[s] = 0;
            end else begin
                if (ld_i) begin
                    md[s] = lv;
                end else if (en_i) begin
                    n = dir_i ? md[s] + st : md[s] - st;
                    if (n > 7 || n < -8) begin
                        o = 1;
                        md[s] = (s == 0) ? (dir_i ? 7 : -8) : wrap4(n);
                    end else begin
                        md[s] = n;
                    end
                end
                ms[s] = ((ms[s] != 0) && !clr_i) || (o != 0) ? 1 : 0;
            end
            e.d[s] = md[s]; e.ovf[s] = o; e.stk[s] = ms[s];
        end
        q.push_back(e);
    endtask

    // Monitor: outputs are valid one cycle after each driven cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("sat_d",      int'($signed(d_s)), e.d[0]);
                chk("sat_ovf",    int'(ovf_s),  e.ovf[0]);
                chk("sat_sticky", int'(stk_s),  e.stk[0]);
                chk("sat_at_min", int'(amin_s), (e.d[0] == -8) ? 1 : 0);
                chk("sat_at_max", int'(amax_s), (e.d[0] == 7) ? 1 : 0);
                chk("wrap_d",      int'($signed(d_w)), e.d[1]);
                chk("wrap_ovf",    int'(ovf_w),  e.ovf[1]);
                chk("wrap_sticky", int'(stk_w),  e.stk[1]);
                chk("wrap_at_min", int'(amin_w), (e.d[1] == -8) ? 1 : 0);
                chk("wrap_at_max", int'(amax_w), (e.d[1] == 7) ? 1 : 0);
            end
        end
    end

    initial begin
        //    rst ld  lv  en dir st clr
        cyc(0, 0,  0, 0, 0, 0, 0);   // reset -> 3, flags clear
        cyc(1, 1,  2, 0, 0, 0, 0);   // load 2
        repeat (4) cyc(1, 0, 0, 1, 0, 1, 0);   // 1,0,-1,-2
        cyc(1, 1, -7, 0, 0, 0, 0);   // load -7
        cyc(1, 0,  0, 1, 0, 3, 0);   // sat -8 ovf / wrap 6 ovf
        cyc(1, 0,  0, 1, 0, 3, 0);   // sat rail again ovf / wrap 3
        cyc(1, 0,  0, 0, 0, 0, 0);   // idle: ovf drops, sticky holds
        cyc(1, 0,  0, 0, 0, 0, 1);   // clear sticky
        cyc(1, 1,  6, 0, 0, 0, 0);   // load 6
        cyc(1, 0,  0, 1, 1, 3, 0);   // sat 7 ovf / wrap -7 ovf
        cyc(1, 0,  0, 0, 0, 0, 0);   // idle
        cyc(1, 1,  5, 1, 1, 3, 1);   // load beats en; clr with no new ovf
        cyc(1, 0,  0, 1, 1, 3, 1);   // new ovf beats clr
        cyc(1, 0,  0, 1, 1, 0, 0);   // step 0: hold, no ovf at rail
        cyc(1, 0,  0, 1, 1, 1, 0);   // sat re-pulses at MAX / wrap -7
        cyc(1, 0,  0, 1, 0, 2, 0);   // step down
        cyc(0, 1,  1, 1, 1, 3, 0);   // reset overrides load and en
        cyc(1, 0,  0, 1, 1, 2, 0);   // 5
        cyc(1, 0,  0, 1, 1, 2, 0);   // 7 exactly, no ovf
        cyc(1, 0,  0, 0, 0, 0, 0);   // hold
        repeat (2) @(posedge Clk);
        #2;
        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
